clk_timebase_min_sec: RTL
=========================

CLK_TIMEBASE_MIN_SEC -- requirements
Module: clk_timebase_min_sec

Interface
REQ-001 Parameter CLK_HZ, default 50000000, CLK cycles per one-second tick; legal range >= 2.
REQ-002 CLK  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 rst_counters  input  1  synchronous clear of all counters and mode.
REQ-005 set_btn  input  1  single-cycle pulse, advances set-mode state.
REQ-006 inc_btn  input  1  single-cycle pulse, increments field selected by set mode.
REQ-007 sec  output  8  seconds, binary 0..59, registered.
REQ-008 min  output  8  minutes, binary 0..59, registered.
REQ-009 count_up_hr  output  1  registered one-cycle strobe to the 24-hour counter.
REQ-010 mode  output  2  current state: 0 RUN, 1 SET_MIN, 2 SET_HR; value 3 never driven.
REQ-011 sec_tick  output  1  registered one-cycle pulse per completed second, RUN only.

Function
REQ-012 Prescaler counts 0..CLK_HZ-1 in RUN; at CLK_HZ-1 it wraps to 0 and raises internal tick for that cycle.
REQ-013 Prescaler held at 0 in SET_MIN and SET_HR; RUN re-entry restarts the count from 0, so the first tick arrives CLK_HZ cycles later.
REQ-014 On tick in RUN: sec <= sec+1; if sec==59 then sec <= 0 and min increments.
REQ-015 On tick with sec==59 and min==59: sec <= 0, min <= 0, count_up_hr high for exactly the cycle in which sec/min show 0.
REQ-016 sec_tick, count_up_hr and the counter update are registered together: latency 1 cycle after the prescaler terminal count.
REQ-017 FSM: RUN -set_btn-> SET_MIN -set_btn-> SET_HR -set_btn-> RUN; no other transitions except reset/rst_counters.
REQ-018 Entering SET_MIN clears sec to 0; sec stays 0 throughout the set states.
REQ-019 SET_MIN + inc_btn: min <= (min==59) ? 0 : min+1; no hour carry, count_up_hr stays low.
REQ-020 SET_HR + inc_btn: count_up_hr high for exactly one cycle (next cycle); min/sec unchanged.
REQ-021 inc_btn in RUN is ignored.
REQ-022 set_btn and inc_btn in the same cycle: set_btn transition taken, inc_btn ignored.
REQ-023 Priority per cycle: rst_counters > set_btn > inc_btn > tick.
REQ-024 rst_counters: next cycle sec=0, min=0, prescaler=0, mode=RUN, count_up_hr=0, sec_tick=0.
REQ-025 Consecutive inc_btn pulses in SET_HR produce one count_up_hr pulse each, back-to-back allowed.
REQ-026 sec and min never exceed 59; counter arithmetic is 8-bit with explicit wrap compare, no modulo operator.

Reset
REQ-027 rst_n low: sec=0, min=0, prescaler=0, mode=RUN, count_up_hr=0, sec_tick=0, immediately, independent of CLK.
REQ-028 Reset asserted mid-second or mid-set-mode discards all state; after release, operation restarts in RUN with a full CLK_HZ-cycle first second.

Structure
REQ-029 Shared package clk_pkg holds mode encodings (RUN/SET_MIN/SET_HR), SEC_MAX=59, MIN_MAX=59.
REQ-030 Prescaler is a sub-module clk_prescaler (parameter CLK_HZ, inputs CLK, rst_n, clr, en; output tick).
REQ-031 count_up_hr connects directly to the hour counter's increment input; hour counter shares CLK, rst_n, rst_counters.

Verification
REQ-032 CLK_HZ=4, run 240 cycles after reset -> sec 0->59->0, min=1, sec_tick pulses every 4 cycles, count_up_hr never high.
REQ-033 CLK_HZ=4, force min=59 via set mode, return to RUN, wait 240 cycles -> single count_up_hr pulse coincident with min=0, sec=0.
REQ-034 set_btn, then 61 inc_btn in SET_MIN -> min wraps 59->0 then reads 1; count_up_hr stays low.
REQ-035 Two set_btn, then 3 back-to-back inc_btn -> count_up_hr high 3 consecutive cycles; third set_btn -> mode=0, first sec_tick 4 cycles later.
REQ-036 set_btn+inc_btn same cycle in RUN -> mode=1, min unchanged; rst_counters during SET_HR with inc_btn -> mode=0, all zero, no count_up_hr.
REQ-037 rst_n pulsed asynchronously mid-second at sec=30 -> outputs zero before next CLK edge; sec_tick 4 cycles after release.

Source files
------------

// File: rtl/clk_pkg.sv
// Shared definitions for the minutes/seconds timebase: mode encodings and
// wrap limits for the seconds and minutes counters.
package clk_pkg;

    typedef enum logic [1:0] {
        MODE_RUN     = 2'd0,
        MODE_SET_MIN = 2'd1,
        MODE_SET_HR  = 2'd2
    } mode_t;

    localparam logic [7:0] SEC_MAX = 8'd59;
    localparam logic [7:0] MIN_MAX = 8'd59;

    // Increment with explicit wrap at a limit (no modulo operator).
    function automatic logic [7:0] wrap_inc(input logic [7:0] value, input logic [7:0] limit);
        return (value == limit) ? 8'd0 : value + 8'd1;
    endfunction

endpackage

// File: rtl/clk_prescaler.sv
// One-second prescaler: counts 0..CLK_HZ-1 while enabled and flags the
// terminal-count cycle. A clear forces the count back to zero.
module clk_prescaler #(
    parameter int CLK_HZ = 50000000
) (
    input  logic CLK,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam logic [CW-1:0] TC = CW'(CLK_HZ - 1);

    logic [CW-1:0] r_cnt;
    logic          w_at_tc;

    assign w_at_tc = (r_cnt == TC);

    // Tick only when the counter really completes a second this cycle.
    assign tick = en && !clr && w_at_tc;

    // Count register: cleared by reset or clr, wraps at terminal count.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            if (w_at_tc) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/clk_timebase_min_sec.sv
// Minutes/seconds timebase with a three-state set mode. Seconds and minutes
// advance from the prescaler tick in RUN; in the set states inc_btn bumps
// minutes or emits an hour strobe to the external 24-hour counter.
module clk_timebase_min_sec
    import clk_pkg::*;
#(
    parameter int CLK_HZ = 50000000
) (
    input  logic       CLK,
    input  logic       rst_n,
    input  logic       rst_counters,
    input  logic       set_btn,
    input  logic       inc_btn,
    output logic [7:0] sec,
    output logic [7:0] min,
    output logic       count_up_hr,
    output logic [1:0] mode,
    output logic       sec_tick
);

    mode_t      r_mode;
    logic [7:0] r_sec;
    logic [7:0] r_min;
    logic       r_count_up_hr;
    logic       r_sec_tick;

    mode_t      w_mode_next;
    logic [7:0] w_sec_next;
    logic [7:0] w_min_next;
    logic       w_count_up_hr_next;
    logic       w_sec_tick_next;

    logic       w_tick;
    logic       w_psc_clr;
    logic       w_psc_en;

    // The prescaler only runs in RUN; leaving RUN, any set state and a
    // counter clear all park it at zero so RUN re-entry gets a full second.
    assign w_psc_en  = (r_mode == MODE_RUN);
    assign w_psc_clr = rst_counters || set_btn || (r_mode != MODE_RUN);

    clk_prescaler #(
        .CLK_HZ (CLK_HZ)
    ) u_prescaler (
        .CLK   (CLK),
        .rst_n (rst_n),
        .clr   (w_psc_clr),
        .en    (w_psc_en),
        .tick  (w_tick)
    );

    // State register for mode, counters and the two output strobes.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_mode        <= MODE_RUN;
            r_sec         <= 8'd0;
            r_min         <= 8'd0;
            r_count_up_hr <= 1'b0;
            r_sec_tick    <= 1'b0;
        end else begin
            r_mode        <= w_mode_next;
            r_sec         <= w_sec_next;
            r_min         <= w_min_next;
            r_count_up_hr <= w_count_up_hr_next;
            r_sec_tick    <= w_sec_tick_next;
        end
    end

    // Next-state logic; priority is clear > set_btn > inc_btn > tick.
    always_comb begin
        w_mode_next        = r_mode;
        w_sec_next         = r_sec;
        w_min_next         = r_min;
        w_count_up_hr_next = 1'b0;
        w_sec_tick_next    = 1'b0;

        if (rst_counters) begin
            w_mode_next = MODE_RUN;
            w_sec_next  = 8'd0;
            w_min_next  = 8'd0;
        end else if (set_btn) begin
            case (r_mode)
                MODE_RUN: begin
                    w_mode_next = MODE_SET_MIN;
                    w_sec_next  = 8'd0;
                end
                MODE_SET_MIN: w_mode_next = MODE_SET_HR;
                MODE_SET_HR:  w_mode_next = MODE_RUN;
                default:      w_mode_next = MODE_RUN;
            endcase
        end else if (inc_btn && (r_mode == MODE_SET_MIN)) begin
            w_min_next = wrap_inc(r_min, MIN_MAX);
        end else if (inc_btn && (r_mode == MODE_SET_HR)) begin
            w_count_up_hr_next = 1'b1;
        end else if (w_tick && (r_mode == MODE_RUN)) begin
            // inc_btn in RUN falls through to here and is ignored.
            w_sec_tick_next = 1'b1;
            w_sec_next      = wrap_inc(r_sec, SEC_MAX);
            if (r_sec == SEC_MAX) begin
                w_min_next = wrap_inc(r_min, MIN_MAX);
                if (r_min == MIN_MAX) begin
                    w_count_up_hr_next = 1'b1;
                end
            end
        end
    end

    assign sec         = r_sec;
    assign min         = r_min;
    assign mode        = r_mode;
    assign count_up_hr = r_count_up_hr;
    assign sec_tick    = r_sec_tick;

endmodule
